// File: rtl/icache_ctrl_pkg.sv
// Shared constants and types for the direct-mapped instruction cache controller.
// Holds the parameter defaults and the refill FSM state encoding.
package icache_ctrl_pkg;

  localparam int DEF_TEXT_BITS  = 12;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 16;
  localparam int WORD_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The fetch unit is the master; the cache controller is the slave.
interface icache_ctrl_if
  import icache_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_TEXT_BITS - 2
) ();

  // Stall protocol: a fetch completes in any cycle with cpu_ren=1 and
  // inst_stall=0; while inst_stall=1 the fetch unit holds cpu_addr. Memory
  // registers mem_addr whenever mem_stall=0 and returns the word next cycle.
  logic              cpu_ren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] inst_out;
  logic              inst_stall;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_stall;
  logic [WORD_W-1:0] mem_dout;

  modport master (
    output cpu_ren, cpu_addr, mem_dout,
    input  inst_out, inst_stall, mem_ren, mem_addr, mem_stall
  );

  modport slave (
    input  cpu_ren, cpu_addr, mem_dout,
    output inst_out, inst_stall, mem_ren, mem_addr, mem_stall
  );

endinterface

// File: rtl/icache_array.sv
// Data, tag and valid storage for the cache: synchronous write, asynchronous read.
// Only the valid bits are cleared by reset; data and tags keep stale contents.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int OFF_W = 2,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_hit_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              tag_we_i,
  input  logic [TAG_W-1:0]  wr_tag_i
);

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << OFF_W;

  logic [WORD_W-1:0] data_q  [LINES*WORDS];
  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [LINES-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  // A line becomes valid only together with its tag, after its last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_data_o = data_q[{rd_idx_i, rd_off_i}];
  assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with zero-latency hits
// and a line refill of LINE_WORDS words from a one-cycle-latency memory.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int TEXT_BITS  = DEF_TEXT_BITS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic          clk,
  input  logic          reset,
  icache_ctrl_if.slave  bus,
  output state_e        dbg_state_o
);

  localparam int ADDR_W = TEXT_BITS - 2;
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

  state_e            state_q;
  logic [LINE_W-1:0] line_q;
  logic [OFF_W-1:0]  req_cnt_q;
  logic [OFF_W-1:0]  ret_cnt_q;
  logic              rd_pend_q;
  logic              mem_ren_q;
  logic              mem_stall_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [LINE_W-1:0] cpu_line;
  logic [WORD_W-1:0] rd_data;
  logic              rd_hit;
  logic              miss;
  logic              fill_wr;
  logic              fill_last;

  assign cpu_line  = bus.cpu_addr[ADDR_W-1:OFF_W];
  assign miss      = (state_q == ST_IDLE) && bus.cpu_ren && !rd_hit;
  // rd_pend_q marks a cycle in which mem_dout carries a word issued last cycle.
  assign fill_wr   = (state_q == ST_REFILL) && rd_pend_q;
  assign fill_last = fill_wr && (ret_cnt_q == CNT_LAST);

  icache_array #(
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx_i  (bus.cpu_addr[OFF_W +: IDX_W]),
    .rd_off_i  (bus.cpu_addr[OFF_W-1:0]),
    .rd_tag_i  (bus.cpu_addr[ADDR_W-1 -: TAG_W]),
    .rd_data_o (rd_data),
    .rd_hit_o  (rd_hit),
    .wr_en_i   (fill_wr),
    .wr_idx_i  (line_q[IDX_W-1:0]),
    .wr_off_i  (ret_cnt_q),
    .wr_data_i (bus.mem_dout),
    .tag_we_i  (fill_last),
    .wr_tag_i  (line_q[LINE_W-1:IDX_W])
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      req_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_stall_q <= 1'b1;
      mem_addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            state_q     <= ST_REFILL;
            line_q      <= cpu_line;
            req_cnt_q   <= '0;
            ret_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            mem_ren_q   <= 1'b1;
            mem_stall_q <= 1'b0;
            mem_addr_q  <= {cpu_line, {OFF_W{1'b0}}};
          end
        end
        ST_REFILL: begin
          rd_pend_q <= mem_ren_q;
          if (mem_ren_q) begin
            req_cnt_q <= req_cnt_q + CNT_ONE;
            if (req_cnt_q == CNT_LAST) begin
              mem_ren_q   <= 1'b0;
              mem_stall_q <= 1'b1;
            end else begin
              mem_addr_q <= {line_q, req_cnt_q + CNT_ONE};
            end
          end
          if (rd_pend_q) begin
            ret_cnt_q <= ret_cnt_q + CNT_ONE;
            if (ret_cnt_q == CNT_LAST) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset gates the combinational fetch outputs so they read as idle during reset.
  assign bus.inst_stall = reset && (miss || (state_q == ST_REFILL));
  assign bus.inst_out   = reset ? rd_data : '0;
  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_stall  = mem_stall_q;
  assign bus.mem_addr   = mem_addr_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus random fetches
// compared cycle by cycle against a line-level model of the cache.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  localparam int TB_ADDR_W = 10;
  localparam int TB_LINES  = 16;
  localparam int PENALTY   = 6;

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_HIT  = 2'd1;
  localparam logic [1:0] K_MISS = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  logic   clk;
  logic   reset;
  state_e dbg_state;

  icache_ctrl_if #(.ADDR_W(TB_ADDR_W)) bus ();

  icache_ctrl #(
    .TEXT_BITS  (12),
    .LINE_WORDS (4),
    .NUM_LINES  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000_0000 + k, registered when not held.
  initial bus.mem_dout = '0;
  always @(posedge clk) begin
    if (!bus.mem_stall) bus.mem_dout <= 32'h1000_0000 + 32'(bus.mem_addr);
  end

  // ---------------- model and scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [33:0]          exp_q[$];
  logic [TB_ADDR_W-1:0] addr_q[$];
  logic [TB_ADDR_W-1:0] mem_log[$];
  bit                   m_valid [TB_LINES];
  logic [3:0]           m_tag   [TB_LINES];
  logic [TB_ADDR_W-1:0] m_last_addr = '0;

  int          stall_run = 0;
  int          last_stall_run = 0;
  logic [31:0] last_done = '0;
  logic [31:0] last_hit = '0;

  function automatic logic [31:0] mem_word(input logic [TB_ADDR_W-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  logic [33:0] cur;
  logic [1:0]  kind;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur  = exp_q.pop_front();
      kind = cur[33:32];
      if (kind == K_MISS) begin
        chk("miss_stall", 32'(bus.inst_stall), 32'd1);
        stall_run++;
        if (bus.mem_ren) begin
          mem_log.push_back(bus.mem_addr);
          chk("fill_mem_stall", 32'(bus.mem_stall), 32'd0);
          chk("fill_req_expected", 32'(addr_q.size() > 0), 32'd1);
          if (addr_q.size() > 0) chk("fill_mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
        end else begin
          chk("miss_mem_stall", 32'(bus.mem_stall), 32'd1);
        end
      end else begin
        chk("stall_low", 32'(bus.inst_stall), 32'd0);
        chk("mem_ren_low", 32'(bus.mem_ren), 32'd0);
        chk("mem_stall_high", 32'(bus.mem_stall), 32'd1);
        chk("mem_addr_hold", 32'(bus.mem_addr), 32'(m_last_addr));
        if (kind == K_HIT) begin
          chk("hit_data", bus.inst_out, cur[31:0]);
          last_hit = bus.inst_out;
        end
        if (kind == K_DONE) begin
          chk("done_data", bus.inst_out, cur[31:0]);
          chk("fill_all_issued", 32'(addr_q.size()), 32'd0);
          last_done      = bus.inst_out;
          last_stall_run = stall_run;
          stall_run      = 0;
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic idle_cycle();
    bus.cpu_ren = 1'b0;
    bus.cpu_addr = TB_ADDR_W'($urandom);
    exp_q.push_back({K_IDLE, 32'h0});
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [TB_ADDR_W-1:0] a);
    logic [3:0]           idx;
    logic [3:0]           tg;
    logic [TB_ADDR_W-1:0] base;
    idx  = a[5:2];
    tg   = a[9:6];
    base = {a[9:2], 2'b00};
    bus.cpu_ren  = 1'b1;
    bus.cpu_addr = a;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      exp_q.push_back({K_HIT, mem_word(a)});
      @(posedge clk); #1;
    end else begin
      for (int w = 0; w < 4; w++) addr_q.push_back(base + TB_ADDR_W'(w));
      for (int c = 0; c < PENALTY; c++) exp_q.push_back({K_MISS, 32'h0});
      exp_q.push_back({K_DONE, mem_word(a)});
      m_last_addr  = base + TB_ADDR_W'(3);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      repeat (PENALTY + 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    bus.cpu_ren  = 1'($urandom_range(0, 1));
    bus.cpu_addr = TB_ADDR_W'($urandom);
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < TB_LINES; i++) m_valid[i] = 1'b0;
    m_last_addr = '0;
    stall_run   = 0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_stall", 32'(bus.inst_stall), 32'd0);
      chk("rst_inst_out", bus.inst_out, 32'd0);
      chk("rst_mem_ren", 32'(bus.mem_ren), 32'd0);
      chk("rst_mem_stall", 32'(bus.mem_stall), 32'd1);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    idle_cycle();
  endtask

  // Miss that is cut short by reset during its third refill cycle.
  task automatic fetch_aborted(input logic [TB_ADDR_W-1:0] a);
    logic [TB_ADDR_W-1:0] base;
    base = {a[9:2], 2'b00};
    bus.cpu_ren  = 1'b1;
    bus.cpu_addr = a;
    for (int w = 0; w < 4; w++) addr_q.push_back(base + TB_ADDR_W'(w));
    for (int c = 0; c < 3; c++) exp_q.push_back({K_MISS, 32'h0});
    repeat (3) @(posedge clk);
    #3;
    apply_reset(2);
  endtask

  task automatic check_fill(input string nm, input logic [TB_ADDR_W-1:0] first,
                            input logic [31:0] data);
    chk({nm, "_stall_cycles"}, 32'(last_stall_run), 32'd6);
    chk({nm, "_data"}, last_done, data);
    chk({nm, "_req_count"}, 32'(mem_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < mem_log.size()) chk({nm, "_req_addr"}, 32'(mem_log[i]), 32'(first) + 32'(i));
    end
  endtask

  // ---------------- main sequence ----------------
  int r;

  initial begin
    reset        = 1'b1;
    bus.cpu_ren  = 1'b0;
    bus.cpu_addr = '0;
    #3;
    apply_reset(3);

    // Cold fetch of word 0.
    mem_log.delete();
    fetch(10'h000);
    check_fill("cold0", 10'h000, 32'h1000_0000);

    // Rest of the same line hits with no memory traffic.
    mem_log.delete();
    fetch(10'h001);
    fetch(10'h002);
    fetch(10'h003);
    chk("line0_hit_last", last_hit, 32'h1000_0003);
    chk("line0_no_req", 32'(mem_log.size()), 32'd0);

    // Conflict on index 0 evicts and re-misses.
    mem_log.delete(); last_stall_run = 0;
    fetch(10'h040);
    check_fill("conflict40", 10'h040, 32'h1000_0040);
    mem_log.delete(); last_stall_run = 0;
    fetch(10'h000);
    check_fill("refetch0", 10'h000, 32'h1000_0000);

    // Cold fetch at offset 3 fills the whole line from offset 0.
    mem_log.delete(); last_stall_run = 0;
    fetch(10'h007);
    check_fill("cold7", 10'h004, 32'h1000_0007);

    // Reset mid-refill, then the same address misses in full.
    fetch_aborted(10'h0a5);
    mem_log.delete(); last_stall_run = 0;
    fetch(10'h0a5);
    check_fill("after_abort", 10'h0a4, 32'h1000_00a5);

    repeat (10) idle_cycle();

    // Random traffic concentrated on a few tags so hits and conflicts both occur.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20) idle_cycle();
      else if (r < 22) apply_reset($urandom_range(1, 3));
      else if (r < 35) fetch(TB_ADDR_W'($urandom));
      else fetch(TB_ADDR_W'($urandom_range(0, 127)));
    end
    repeat (2) idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
